ads_multi_ctl: RTL and testbench
================================

Name: ads_multi_ctl

Overview:
- Parametrised successor to the existing two-lane ADS serial ADC controller.
- Single CLK_100M domain. ADS_CLK is derived internally from a clock-enable divider, not taken from a separate clock.
- Runs the fixed ADC init command sequence, then launches one conversion/readback frame per AFE trigger edge.
- Captures N_LANES serial outputs, strips and checks each lane's tag bits, and presents per-lane data plus valid bits to the downstream packer.

Parameters:
- N_LANES, 2, number of ADS_SDO lines sampled in parallel (1..8)
- DATA_W, 16, data bits per lane
- TAG_W, 2, tag bits preceding data on each lane (channel/chip ID)
- CMD_W, 16, SDI command width
- FRAME_BITS, 20, ADS_CLK periods per CS_N-low frame; must be >= TAG_W+DATA_W+2 and >= CMD_W+1
- CLK_DIV, 4, CLK_100M cycles per ADS_CLK half-period (>=2)
- SYNC_PERIOD, 34, AFE edges per AFE line cycle
- ACTIVE_EDGES, 32, leading edges of each line cycle that trigger conversions

Ports:
- CLK_100M  in  1  system clock
- CLK_RST  in  1  reset, synchronous, active-high
- CLK_AFE  in  1  AFE trigger, asynchronous; 2-FF synchronised inside, rising edge used
- ADS_CLK  out  1  serial clock, CLK_100M/(2*CLK_DIV), free-running after reset
- ADS_CS_N  out  1  frame select, low during frame
- ADS_CONVST  out  1  conversion start
- ADS_RD  out  1  read strobe
- ADS_SDI  out  1  command bit stream, MSB first
- ADS_M  out  2  mode pins, constant 2'b00
- ADS_SDO  in  N_LANES  serial data, bit i = lane i
- ADS_BUSY  in  1  monitored only; no behaviour depends on it
- ADS_DATA  out  N_LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- ADS_VALID  out  N_LANES  per-lane valid, held until next frame's CHECK
- ADS_STROBE  out  1  one-cycle pulse when ADS_DATA/ADS_VALID update
- ADS_OVR  out  1  one-cycle pulse when an active AFE edge arrives while a frame is in progress
- ADS_INIT_OK  out  1  init sequence complete

Behaviour:
- Reset: ADS_CLK=0, CS_N=1, CONVST=0, RD=0, SDI=0, DATA=0, VALID=0, STROBE=0, OVR=0, INIT_OK=0, all counters 0, state IDLE.
- Reset asserted mid-frame aborts the frame at the next edge: CS_N=1 and the init sequence restarts.
- Divider: tick every CLK_DIV cycles toggles ADS_CLK.
  - rise event = tick with ADS_CLK 0->1
  - fall event = tick with ADS_CLK 1->0
- Frame: bit counter k=0..FRAME_BITS-1 advances on rise events.
  - CS_N goes low at the rise event for k=0.
  - CONVST=RD=1 for bit period k=0 only.
  - SDI = cmd[CMD_W-k] for k=1..CMD_W, otherwise 0.
  - SDO is sampled on the fall events of k=2..TAG_W+DATA_W+1 into per-lane shift registers, MSB first.
  - CS_N goes high at the rise event after k=FRAME_BITS-1, followed by one full ADS_CLK period of gap.
- States:
  - IDLE: if !INIT_OK -> LOAD; else an active AFE edge -> LOAD.
  - LOAD: one cycle; latch command; wait for next rise event -> FRAME.
  - FRAME: runs to frame end -> GAP.
  - GAP: one ADS_CLK period. If INIT_OK, -> CHECK. Otherwise, if the command index is INIT, set INIT_OK and -> IDLE; else -> LOAD.
  - CHECK: one cycle; update outputs; STROBE=1; -> IDLE.
- Init commands in order: 0x0004 SRESET, 0x0002 REFV1, 0x07FF DAC, 0x0005 REFV2, 0x07FF DAC, 0x4010 INIT. After INIT_OK, every frame sends NORM 0x0000.
- No DATA/VALID updates before INIT_OK.
- AFE counter:
  - Counts synchronised rising edges and wraps from SYNC_PERIOD-1 to 0.
  - An edge is active when the pre-increment count < ACTIVE_EDGES; active edges start frames, other edges are ignored.
  - An active edge arriving outside IDLE starts no frame and pulses OVR, never queued.
  - Simultaneous edge and frame end: the edge counts as overrun.
- CHECK, per lane i:
  - VALID[i] = (tag == i mod 2^TAG_W).
  - DATA lane = shifted data if valid, else 0.

Optional Feature:
- Macro ADS_TAG_CHECK_EN.
- Defined: per-lane tag compare as above.
- Undefined: tags are discarded, and every lane has VALID=1 with data captured on each CHECK.

Decomposition:
- Package ads_pkg holds:
  - state enum (IDLE, LOAD, FRAME, GAP, CHECK)
  - the six init command constants and CMD_NORM
  - command index constants
- Sub-module ads_sclk_gen: divider producing ADS_CLK, rise event and fall event.

Test Plan:
- Reset release, no AFE edges -> exactly 6 frames whose SDI decodes to 0x0004, 0x0002, 0x07FF, 0x0005, 0x07FF, 0x4010; INIT_OK rises after the 6th GAP; ADS_CLK period 80 ns.
- Post-init AFE edge, model drives lane0 tag 00 data 0xA5C3 and lane1 tag 01 data 0x1234 -> STROBE once, VALID=2'b11, DATA={0x1234,0xA5C3}, SDI all zero.
- Lane1 tag 00 -> VALID=2'b01 and lane1 data 0; with ADS_TAG_CHECK_EN undefined -> VALID=2'b11.
- 34 AFE edges spaced wider than one frame -> 32 frames, then edges 33 and 34 ignored; the next cycle's first edge starts a frame.
- Second AFE edge issued 200 ns into a frame -> OVR pulses once, no extra frame, current frame completes normally.
- CLK_RST asserted during frame bit 10 -> next cycle CS_N=1, INIT_OK=0, VALID=0; init sequence restarts from SRESET.

Source files
------------

// File: rtl/ads_pkg.sv
// ads_pkg: shared FSM states, ADC init command set and command indices
package ads_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, FRAME, GAP, CHECK} state_t;

    localparam logic [15:0] CMD_SRESET = 16'h0004;
    localparam logic [15:0] CMD_REFV1  = 16'h0002;
    localparam logic [15:0] CMD_DAC    = 16'h07FF;
    localparam logic [15:0] CMD_REFV2  = 16'h0005;
    localparam logic [15:0] CMD_INIT   = 16'h4010;
    localparam logic [15:0] CMD_NORM   = 16'h0000;

    localparam logic [2:0] IDX_SRESET = 3'd0;
    localparam logic [2:0] IDX_REFV1  = 3'd1;
    localparam logic [2:0] IDX_DAC1   = 3'd2;
    localparam logic [2:0] IDX_REFV2  = 3'd3;
    localparam logic [2:0] IDX_DAC2   = 3'd4;
    localparam logic [2:0] IDX_INIT   = 3'd5;

    function automatic logic [15:0] init_cmd(input logic [2:0] idx);
        return idx == IDX_SRESET ? CMD_SRESET :
               idx == IDX_REFV1  ? CMD_REFV1  :
               idx == IDX_DAC1   ? CMD_DAC    :
               idx == IDX_REFV2  ? CMD_REFV2  :
               idx == IDX_DAC2   ? CMD_DAC    : CMD_INIT;
    endfunction

endpackage

// File: rtl/ads_multi_ctl_if.sv
// ads_multi_ctl_if: ADC serial pins plus per-lane result bus to the packer
interface ads_multi_ctl_if #(
    parameter int N_LANES = 2,
    parameter int DATA_W  = 16
);
    logic                        ADS_CLK;
    logic                        ADS_CS_N;
    logic                        ADS_CONVST;
    logic                        ADS_RD;
    logic                        ADS_SDI;
    logic [1:0]                  ADS_M;
    logic [N_LANES-1:0]          ADS_SDO;
    logic                        ADS_BUSY;
    logic [N_LANES*DATA_W-1:0]   ADS_DATA;
    logic [N_LANES-1:0]          ADS_VALID;
    logic                        ADS_STROBE;
    logic                        ADS_OVR;
    logic                        ADS_INIT_OK;

    modport master (
        output ADS_CLK, ADS_CS_N, ADS_CONVST, ADS_RD, ADS_SDI, ADS_M,
        output ADS_DATA, ADS_VALID, ADS_STROBE, ADS_OVR, ADS_INIT_OK,
        input  ADS_SDO, ADS_BUSY
    );

    modport slave (
        input  ADS_CLK, ADS_CS_N, ADS_CONVST, ADS_RD, ADS_SDI, ADS_M,
        input  ADS_DATA, ADS_VALID, ADS_STROBE, ADS_OVR, ADS_INIT_OK,
        output ADS_SDO, ADS_BUSY
    );
endinterface

// File: rtl/ads_sclk_gen.sv
// ads_sclk_gen: clock-enable divider producing ADS_CLK and its rise/fall events
module ads_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = cnt == LAST;
    assign rise = tick & ~sclk;
    assign fall = tick & sclk;

    // toggle the serial clock once every CLK_DIV system cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) sclk <= ~sclk;
        end
    end
endmodule

// File: rtl/ads_multi_ctl.sv
// ads_multi_ctl: N-lane ADS serial ADC controller (init sequence, AFE-triggered frames)
// Build option: define ADS_TAG_CHECK_EN to validate each lane's tag bits against its lane index.
module ads_multi_ctl
    import ads_pkg::*;
#(
    parameter int N_LANES      = 2,
    parameter int DATA_W       = 16,
    parameter int TAG_W        = 2,
    parameter int CMD_W        = 16,
    parameter int FRAME_BITS   = 20,
    parameter int CLK_DIV      = 4,
    parameter int SYNC_PERIOD  = 34,
    parameter int ACTIVE_EDGES = 32
) (
    input logic            CLK_100M,
    input logic            CLK_RST,
    input logic            CLK_AFE,
    ads_multi_ctl_if.master bus
);
    localparam int W  = TAG_W + DATA_W;
`ifdef ADS_TAG_CHECK_EN
    localparam int SW = W;
`else
    localparam int SW = DATA_W;
`endif
    localparam int KW = $clog2(FRAME_BITS);
    localparam int AW = $clog2(SYNC_PERIOD);

    logic               rise, fall;
    logic [2:0]         afe_s;
    logic [AW-1:0]      afe_cnt;
    logic               afe_edge, active;
    state_t             state;
    logic [2:0]         idx;
    logic [CMD_W-1:0]   cmd;
    logic [KW-1:0]      k;
    logic [SW-1:0]      sh [N_LANES];
    logic [N_LANES-1:0] lane_ok;

    ads_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk  (CLK_100M),
        .rst  (CLK_RST),
        .sclk (bus.ADS_CLK),
        .rise (rise),
        .fall (fall)
    );

    assign bus.ADS_M = 2'b00;
    assign afe_edge  = afe_s[1] & ~afe_s[2];
    assign active    = afe_edge && (int'(afe_cnt) < ACTIVE_EDGES);

    // synchronise the AFE trigger and count its rising edges over the line cycle
    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) begin
            afe_s   <= '0;
            afe_cnt <= '0;
        end else begin
            afe_s <= {afe_s[1:0], CLK_AFE};
            if (afe_edge) afe_cnt <= afe_cnt == AW'(SYNC_PERIOD - 1) ? '0 : afe_cnt + AW'(1);
        end
    end

    // per-lane acceptance: tag must equal the lane index when checking is built in
    always_comb begin
        lane_ok = '1;
`ifdef ADS_TAG_CHECK_EN
        for (int i = 0; i < N_LANES; i++) lane_ok[i] = sh[i][W-1 -: TAG_W] == TAG_W'(i);
`endif
    end

    // frame sequencer: init commands first, then one NORM frame per active AFE edge
    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) begin
            state           <= IDLE;
            idx             <= '0;
            cmd             <= '0;
            k               <= '0;
            bus.ADS_CS_N    <= 1'b1;
            bus.ADS_CONVST  <= 1'b0;
            bus.ADS_RD      <= 1'b0;
            bus.ADS_SDI     <= 1'b0;
            bus.ADS_DATA    <= '0;
            bus.ADS_VALID   <= '0;
            bus.ADS_STROBE  <= 1'b0;
            bus.ADS_OVR     <= 1'b0;
            bus.ADS_INIT_OK <= 1'b0;
            for (int i = 0; i < N_LANES; i++) sh[i] <= '0;
        end else begin
            bus.ADS_STROBE <= 1'b0;
            bus.ADS_OVR    <= active && (state != IDLE || !bus.ADS_INIT_OK);
            case (state)
                IDLE: if (!bus.ADS_INIT_OK || active) state <= LOAD;
                LOAD: begin
                    cmd <= bus.ADS_INIT_OK ? CMD_W'(CMD_NORM) : CMD_W'(init_cmd(idx));
                    if (rise) begin
                        state          <= FRAME;
                        k              <= '0;
                        bus.ADS_CS_N   <= 1'b0;
                        bus.ADS_CONVST <= 1'b1;
                        bus.ADS_RD     <= 1'b1;
                        bus.ADS_SDI    <= 1'b0;
                    end
                end
                FRAME: begin
                    // the command shifts out MSB first; once empty it keeps SDI at zero
                    if (rise) begin
                        if (k == KW'(FRAME_BITS - 1)) begin
                            bus.ADS_CS_N <= 1'b1;
                            bus.ADS_SDI  <= 1'b0;
                            state        <= GAP;
                        end else begin
                            k              <= k + KW'(1);
                            bus.ADS_CONVST <= 1'b0;
                            bus.ADS_RD     <= 1'b0;
                            bus.ADS_SDI    <= cmd[CMD_W-1];
                            cmd            <= {cmd[CMD_W-2:0], 1'b0};
                        end
                    end
                    if (fall && int'(k) >= 2 && int'(k) <= W + 1)
                        for (int i = 0; i < N_LANES; i++) sh[i] <= {sh[i][SW-2:0], bus.ADS_SDO[i]};
                end
                GAP: if (rise) begin
                    if (bus.ADS_INIT_OK) state <= CHECK;
                    else if (idx == IDX_INIT) begin
                        bus.ADS_INIT_OK <= 1'b1;
                        idx             <= '0;
                        state           <= IDLE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= LOAD;
                    end
                end
                CHECK: begin
                    bus.ADS_STROBE <= 1'b1;
                    state          <= IDLE;
                    bus.ADS_VALID  <= lane_ok;
                    for (int i = 0; i < N_LANES; i++)
                        bus.ADS_DATA[i*DATA_W +: DATA_W] <= lane_ok[i] ? sh[i][DATA_W-1:0] : '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ads_multi_ctl.sv
// tb_ads_multi_ctl: directed bench with an ADC lane model and SDI command decoder
module tb_ads_multi_ctl;
    localparam int W = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic afe = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   strobe_cnt = 0;
    int   ovr_cnt = 0;
    int   frame_cnt = 0;
    logic cs_prev = 1'b0;
    int   kk = -1;
    logic [15:0] cap = '0;
    logic [15:0] cmds[$];
    logic [W-1:0] lane_word [2];
    logic [15:0] exp_init [6] = '{16'h0004, 16'h0002, 16'h07FF, 16'h0005, 16'h07FF, 16'h4010};

    ads_multi_ctl_if #(.N_LANES(2), .DATA_W(16)) bus ();

    ads_multi_ctl #(
        .N_LANES(2), .DATA_W(16), .TAG_W(2), .CMD_W(16), .FRAME_BITS(20),
        .CLK_DIV(4), .SYNC_PERIOD(34), .ACTIVE_EDGES(32)
    ) dut (
        .CLK_100M (clk),
        .CLK_RST  (rst),
        .CLK_AFE  (afe),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // ADC model: track bit index per ADS_CLK rise, drive SDO, collect finished commands
    always @(posedge bus.ADS_CLK) begin
        #1;
        if (bus.ADS_CS_N) begin
            if (kk >= 0) cmds.push_back(cap);
            kk = -1;
        end else begin
            kk = kk + 1;
            if (kk == 0) cap = '0;
        end
        for (int i = 0; i < 2; i++)
            bus.ADS_SDO[i] = (kk >= 2 && kk <= W + 1) ? lane_word[i][W+1-kk] : 1'b0;
    end

    always @(posedge rst) begin
        kk  = -1;
        cap = '0;
    end

    always @(negedge bus.ADS_CLK)
        if (!bus.ADS_CS_N && kk >= 1 && kk <= 16) cap = {cap[14:0], bus.ADS_SDI};

    always @(negedge clk) begin
        if (bus.ADS_STROBE) strobe_cnt++;
        if (bus.ADS_OVR) ovr_cnt++;
        if (cs_prev && !bus.ADS_CS_N) frame_cnt++;
        cs_prev = bus.ADS_CS_N;
    end

    task automatic pulse_afe();
        afe = 1'b1;
        #60;
        afe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.ADS_CS_N !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", bus.ADS_CS_N); end
        checks++;
        if ({bus.ADS_CLK, bus.ADS_CONVST, bus.ADS_RD, bus.ADS_SDI} !== 4'b0000) begin
            errors++; $display("FAIL reset_pins: got %b want 0000", {bus.ADS_CLK, bus.ADS_CONVST, bus.ADS_RD, bus.ADS_SDI});
        end
        checks++;
        if ({bus.ADS_DATA, bus.ADS_VALID} !== 34'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {bus.ADS_DATA, bus.ADS_VALID});
        end
        checks++;
        if ({bus.ADS_STROBE, bus.ADS_OVR, bus.ADS_INIT_OK, bus.ADS_M} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {bus.ADS_STROBE, bus.ADS_OVR, bus.ADS_INIT_OK, bus.ADS_M});
        end
    endtask

    task automatic test_init();
        int f0, first, per, n;
        logic prev;
        f0 = frame_cnt;
        cmds.delete();
        rst = 1'b0;
        first = -1;
        per = 0;
        prev = bus.ADS_CLK;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!prev && bus.ADS_CLK) begin
                if (first >= 0 && per == 0) per = c - first;
                if (first < 0) first = c;
            end
            prev = bus.ADS_CLK;
        end
        checks++;
        if (per !== 8) begin errors++; $display("FAIL sclk_period: got %0d cycles want 8", per); end
        n = 0;
        while (!bus.ADS_INIT_OK && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (bus.ADS_INIT_OK !== 1'b1) begin errors++; $display("FAIL init_ok: got %b want 1", bus.ADS_INIT_OK); end
        checks++;
        if (frame_cnt - f0 !== 6) begin errors++; $display("FAIL init_frames_at_ok: got %0d want 6", frame_cnt - f0); end
        checks++;
        if (cmds.size() !== 6) begin errors++; $display("FAIL init_cmd_count: got %0d want 6", cmds.size()); end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (j >= cmds.size() || cmds[j] !== exp_init[j]) begin
                errors++; $display("FAIL init_cmd%0d: got %h want %h", j, j < cmds.size() ? cmds[j] : 16'hxxxx, exp_init[j]);
            end
        end
        repeat (300) @(negedge clk);
        checks++;
        if (frame_cnt - f0 !== 6) begin errors++; $display("FAIL init_idle: got %0d frames want 6", frame_cnt - f0); end
    endtask

    task automatic test_sync();
        int s0;
        lane_word[0] = {2'b00, 16'h1111};
        lane_word[1] = {2'b01, 16'h2222};
        for (int e = 1; e <= 35; e++) begin
            s0 = strobe_cnt;
            pulse_afe();
            repeat (250) @(negedge clk);
            checks++;
            if (strobe_cnt - s0 !== ((e == 33 || e == 34) ? 0 : 1)) begin
                errors++; $display("FAIL sync_edge%0d: got %0d strobes want %0d", e, strobe_cnt - s0, (e == 33 || e == 34) ? 0 : 1);
            end
        end
        checks++;
        if (ovr_cnt !== 0) begin errors++; $display("FAIL sync_ovr: got %0d want 0", ovr_cnt); end
    endtask

    task automatic test_data();
        int s0;
        lane_word[0] = {2'b00, 16'hA5C3};
        lane_word[1] = {2'b01, 16'h1234};
        s0 = strobe_cnt;
        cmds.delete();
        pulse_afe();
        repeat (250) @(negedge clk);
        checks++;
        if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL data_strobe: got %0d want 1", strobe_cnt - s0); end
        checks++;
        if (bus.ADS_VALID !== 2'b11) begin errors++; $display("FAIL data_valid: got %b want 11", bus.ADS_VALID); end
        checks++;
        if (bus.ADS_DATA !== 32'h1234_A5C3) begin errors++; $display("FAIL data_word: got %h want 1234a5c3", bus.ADS_DATA); end
        checks++;
        if (cmds.size() !== 1 || cmds[0] !== 16'h0000) begin
            errors++; $display("FAIL data_sdi: got %0d cmds first %h want 1 cmd 0000", cmds.size(), cmds.size() > 0 ? cmds[0] : 16'hxxxx);
        end
    endtask

    task automatic test_tag();
        logic [1:0]  ev;
        logic [31:0] ed;
`ifdef ADS_TAG_CHECK_EN
        ev = 2'b01;
        ed = 32'h0000_5A5A;
`else
        ev = 2'b11;
        ed = 32'h9876_5A5A;
`endif
        lane_word[0] = {2'b00, 16'h5A5A};
        lane_word[1] = {2'b00, 16'h9876};
        pulse_afe();
        repeat (250) @(negedge clk);
        checks++;
        if (bus.ADS_VALID !== ev) begin errors++; $display("FAIL tag_valid: got %b want %b", bus.ADS_VALID, ev); end
        checks++;
        if (bus.ADS_DATA !== ed) begin errors++; $display("FAIL tag_data: got %h want %h", bus.ADS_DATA, ed); end
    endtask

    task automatic test_ovr();
        int s0, o0, f0, n;
        lane_word[0] = {2'b00, 16'h0F0F};
        lane_word[1] = {2'b01, 16'hF00F};
        s0 = strobe_cnt;
        o0 = ovr_cnt;
        f0 = frame_cnt;
        pulse_afe();
        n = 0;
        while (bus.ADS_CS_N && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (bus.ADS_CS_N !== 1'b0) begin errors++; $display("FAIL ovr_frame_start: got cs_n %b want 0", bus.ADS_CS_N); end
        #200;
        pulse_afe();
        repeat (400) @(negedge clk);
        checks++;
        if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0); end
        checks++;
        if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL ovr_frames: got %0d want 1", frame_cnt - f0); end
        checks++;
        if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL ovr_strobe: got %0d want 1", strobe_cnt - s0); end
        checks++;
        if (bus.ADS_DATA !== 32'hF00F_0F0F || bus.ADS_VALID !== 2'b11) begin
            errors++; $display("FAIL ovr_data: got %h/%b want f00f0f0f/11", bus.ADS_DATA, bus.ADS_VALID);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        pulse_afe();
        n = 0;
        while (kk != 10 && n < 600) begin @(negedge clk); n++; end
        checks++;
        if (kk != 10) begin errors++; $display("FAIL rstmid_bit10: got bit %0d want 10", kk); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.ADS_CS_N, bus.ADS_INIT_OK, bus.ADS_VALID} !== 4'b1000) begin
            errors++; $display("FAIL rstmid_state: got %b want 1000", {bus.ADS_CS_N, bus.ADS_INIT_OK, bus.ADS_VALID});
        end
        repeat (3) @(negedge clk);
        cmds.delete();
        rst = 1'b0;
        n = 0;
        while (cmds.size() == 0 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (cmds.size() == 0 || cmds[0] !== 16'h0004) begin
            errors++; $display("FAIL rstmid_restart: got %h want 0004", cmds.size() > 0 ? cmds[0] : 16'hxxxx);
        end
    endtask

    initial begin
        bus.ADS_SDO  = '0;
        bus.ADS_BUSY = 1'b0;
        lane_word[0] = '0;
        lane_word[1] = '0;
        test_reset();
        test_init();
        test_sync();
        test_data();
        test_tag();
        test_ovr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
